// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request sequencer.
package gcd_pkg;

  // Request sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int unsigned GcdWidth   = 16;
  localparam int unsigned GcdTimeout = 1024;

endpackage

// File: rtl/gcd_req_ctrl_if.sv
// Operand request and result response handshakes of the GCD request sequencer.
interface gcd_req_ctrl_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdWidth
);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_gcd;
  logic             res_err;

  // Requester / result consumer side.
  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_gcd, res_err
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_gcd, res_err
  );
endinterface

// File: rtl/gcd_timeout_counter.sv
// Cycle counter for one RUN phase; expired_o flags the last allowed cycle.
module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = GcdTimeout
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear before each job, count while enabled; the FSM leaves RUN before a wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_req_ctrl.sv
// Request sequencer in front of the GCD core: holds the core in reset between
// jobs, runs one job per operand pair, and returns the result or a timeout.
module gcd_req_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH   = GcdWidth,
  parameter int unsigned TIMEOUT = GcdTimeout
) (
  input  logic             clk_i,
  input  logic             reset_i,
  gcd_req_ctrl_if.slave    req_if,
  output logic             core_nreset_o,
  output logic             core_enable_o,
  output logic [WIDTH-1:0] core_a_o,
  output logic [WIDTH-1:0] core_b_o,
  input  logic             core_finish_i,
  input  logic [WIDTH-1:0] core_result_i,
  output logic             busy_o
);
  state_e           state_q;
  logic             op_ready_q;
  logic             core_nreset_q;
  logic             core_enable_q;
  logic [WIDTH-1:0] core_a_q;
  logic [WIDTH-1:0] core_b_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_gcd_q;
  logic             res_err_q;
  logic             busy_q;

  logic op_xfer;
  logic res_xfer;
  logic cnt_clear;
  logic cnt_en;
  logic cnt_expired;

  // op_ready_q is only ever high in S_IDLE, so it alone qualifies a transfer.
  assign op_xfer   = req_if.op_valid & op_ready_q;
  assign res_xfer  = res_valid_q & req_if.res_ready;
  assign cnt_clear = (state_q == S_LOAD);
  assign cnt_en    = (state_q == S_RUN);

  gcd_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (cnt_clear),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      op_ready_q    <= 1'b0;
      core_nreset_q <= 1'b0;
      core_enable_q <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      res_valid_q   <= 1'b0;
      res_gcd_q     <= '0;
      res_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          op_ready_q <= 1'b1;
          if (op_xfer) begin
            op_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            core_a_q   <= req_if.op_a;
            core_b_q   <= req_if.op_b;
            if ((req_if.op_a == '0) || (req_if.op_b == '0)) begin
              // gcd(x,0)=x, answered without touching the core.
              res_gcd_q   <= req_if.op_a | req_if.op_b;
              res_err_q   <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          core_nreset_q <= 1'b1;
          core_enable_q <= 1'b1;
          state_q       <= S_RUN;
        end
        S_RUN: begin
          if (core_finish_i) begin
            res_gcd_q     <= core_result_i;
            res_err_q     <= 1'b0;
            res_valid_q   <= 1'b1;
            core_nreset_q <= 1'b0;
            core_enable_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (cnt_expired) begin
            res_gcd_q     <= '0;
            res_err_q     <= 1'b1;
            res_valid_q   <= 1'b1;
            core_nreset_q <= 1'b0;
            core_enable_q <= 1'b0;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_xfer) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_if.op_ready  = op_ready_q;
  assign req_if.res_valid = res_valid_q;
  assign req_if.res_gcd   = res_gcd_q;
  assign req_if.res_err   = res_err_q;
  assign core_nreset_o    = core_nreset_q;
  assign core_enable_o    = core_enable_q;
  assign core_a_o         = core_a_q;
  assign core_b_o         = core_b_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_gcd_req_ctrl.sv
// Scoreboard bench for gcd_req_ctrl with a behavioural GCD core.
module tb_gcd_req_ctrl;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 8;

  logic         clk;
  logic         reset;
  logic         core_nreset;
  logic         core_enable;
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_finish = 1'b0;
  logic [W-1:0] core_result = '0;
  logic         busy;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [16:0]  exp_q[$];

  // Behavioural core controls.
  int           core_lat   = 5;
  logic [W-1:0] core_val   = '0;
  bit           core_never = 1'b0;
  int           core_cnt   = 0;

  gcd_req_ctrl_if #(.WIDTH(W)) req_if ();

  gcd_req_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_if        (req_if),
    .core_nreset_o (core_nreset),
    .core_enable_o (core_enable),
    .core_a_o      (core_a),
    .core_b_o      (core_b),
    .core_finish_i (core_finish),
    .core_result_i (core_result),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Core raises finish core_lat enabled cycles after release and holds it until reset.
  always @(posedge clk) begin
    if (!core_nreset) begin
      core_cnt    <= 0;
      core_finish <= 1'b0;
    end else if (core_enable) begin
      core_cnt <= core_cnt + 1;
      if (!core_never && (core_cnt + 1 == core_lat)) begin
        core_finish <= 1'b1;
        core_result <= core_val;
      end
    end
  end

  // Result monitor: pop and compare on every completed result handshake.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset && req_if.res_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_res_valid", 32'(req_if.res_valid), 32'd0);
      end else if (req_if.res_ready) begin
        e = exp_q.pop_front();
        check_eq("res_gcd", 32'(req_if.res_gcd), 32'(e[15:0]));
        check_eq("res_err", 32'(req_if.res_err), 32'(e[16]));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                      input logic err, input logic [W-1:0] gcd);
    int n = 0;
    @(posedge clk); #1;
    req_if.op_valid = 1'b1;
    req_if.op_a     = a;
    req_if.op_b     = b;
    while (n < 40) begin
      @(negedge clk);
      if (req_if.op_ready) break;
      n++;
    end
    if (!req_if.op_ready) begin
      check_eq("send_timeout", 32'(req_if.op_ready), 32'd1);
      req_if.op_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back({err, gcd});
    @(posedge clk); #1;
    req_if.op_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (req_if.res_valid) break;
    end
    if (!req_if.res_valid) check_eq("res_wait_timeout", 32'(req_if.res_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (req_if.op_ready) break;
      n++;
    end
    if (!req_if.op_ready) check_eq("idle_wait_timeout", 32'(req_if.op_ready), 32'd1);
  endtask

  // Runs a core job with res_ready high and checks the enable-to-result latency.
  task automatic core_job(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                          input bit never, input logic [W-1:0] val, input logic err,
                          input logic [W-1:0] gcd, input int exp_cyc, input string tag);
    int cyc;
    core_lat   = lat;
    core_never = never;
    core_val   = val;
    send(a, b, 1'b1, err, gcd);
    @(negedge clk);
    check_eq({tag, "_load_nreset"}, 32'(core_nreset), 32'd0);
    check_eq({tag, "_load_core_a"}, 32'(core_a), 32'(a));
    @(negedge clk);
    check_eq({tag, "_run_enable"}, 32'(core_enable), 32'd1);
    check_eq({tag, "_run_nreset"}, 32'(core_nreset), 32'd1);
    wait_res(cyc);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, "_resp_nreset"}, 32'(core_nreset), 32'd0);
    check_eq({tag, "_resp_enable"}, 32'(core_enable), 32'd0);
    wait_idle();
  endtask

  initial begin
    int cyc;
    reset            = 1'b1;
    req_if.op_valid  = 1'b0;
    req_if.op_a      = '0;
    req_if.op_b      = '0;
    req_if.res_ready = 1'b1;
    repeat (3) @(negedge clk);

    check_eq("rst_op_ready", 32'(req_if.op_ready), 32'd0);
    check_eq("rst_nreset", 32'(core_nreset), 32'd0);
    check_eq("rst_res_valid", 32'(req_if.res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("op_ready_after_rst", 32'(req_if.op_ready), 32'd1);

    // Normal job: finish 5 cycles after enable, result one cycle later.
    core_job(16'd48, 16'd18, 5, 1'b0, 16'd6, 1'b0, 16'd6, 6, "normal");

    // Zero-operand bypass.
    send(16'd0, 16'd35, 1'b1, 1'b0, 16'd35);
    @(negedge clk);
    check_eq("byp_res_valid", 32'(req_if.res_valid), 32'd1);
    check_eq("byp_nreset", 32'(core_nreset), 32'd0);
    @(negedge clk);
    check_eq("byp_op_ready", 32'(req_if.op_ready), 32'd1);
    check_eq("byp_nreset2", 32'(core_nreset), 32'd0);
    send(16'd0, 16'd0, 1'b1, 1'b0, 16'd0);
    wait_idle();

    // Timeout and finish/timeout collision.
    core_job(16'd20, 16'd6, 5, 1'b1, 16'd2, 1'b1, 16'd0, TO, "timeout");
    core_job(16'd27, 16'd18, 7, 1'b0, 16'd9, 1'b0, 16'd9, TO, "collide");

    // Backpressure with toggling requests.
    req_if.res_ready = 1'b0;
    core_lat = 3; core_never = 1'b0; core_val = 16'd5;
    send(16'd15, 16'd10, 1'b1, 1'b0, 16'd5);
    wait_res(cyc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_if.op_valid = i[0];
      req_if.op_a     = 16'(100 + i);
      req_if.op_b     = 16'd3;
      @(negedge clk);
      check_eq("bp_res_valid", 32'(req_if.res_valid), 32'd1);
      check_eq("bp_res_gcd", 32'(req_if.res_gcd), 32'd5);
      check_eq("bp_op_ready", 32'(req_if.op_ready), 32'd0);
      check_eq("bp_core_a", 32'(core_a), 32'd15);
    end
    @(posedge clk); #1;
    req_if.op_valid  = 1'b0;
    req_if.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_op_ready_after", 32'(req_if.op_ready), 32'd1);
    check_eq("bp_res_valid_after", 32'(req_if.res_valid), 32'd0);
    core_job(16'd21, 16'd14, 4, 1'b0, 16'd7, 1'b0, 16'd7, 5, "after_bp");

    // Reset in the middle of RUN.
    core_lat = 6; core_never = 1'b0; core_val = 16'd6;
    send(16'd30, 16'd12, 1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    check_eq("mid_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("mid_op_ready", 32'(req_if.op_ready), 32'd0);
    check_eq("mid_nreset", 32'(core_nreset), 32'd0);
    check_eq("mid_enable", 32'(core_enable), 32'd0);
    check_eq("mid_core_a", 32'(core_a), 32'd0);
    check_eq("mid_core_b", 32'(core_b), 32'd0);
    check_eq("mid_res_valid", 32'(req_if.res_valid), 32'd0);
    check_eq("mid_res_gcd", 32'(req_if.res_gcd), 32'd0);
    check_eq("mid_res_err", 32'(req_if.res_err), 32'd0);
    check_eq("mid_busy_rst", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_op_ready_rel", 32'(req_if.op_ready), 32'd1);
    core_job(16'd12, 16'd8, 3, 1'b0, 16'd4, 1'b0, 16'd4, 4, "after_rst");

    repeat (3) @(negedge clk);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
